// File: rtl/sram_arb_2p_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : sram_arb_2p_if                                                 |
// | Brief    : Two-requester request/grant/response bundle for sram_arb_2p.   |
// | Revision : 1.0                                                            |
// ----------------------------------------------------------------------------
interface sram_arb_2p_if #(
    parameter int ADDR_WIDTH = 9
);
    logic [1:0]                 Req_SI;
    logic [1:0]                 Gnt_SO;
    logic [1:0]                 WrEn_SI;
    logic [1:0][7:0]            BEn_SI;
    logic [1:0][63:0]           WrData_DI;
    logic [1:0][ADDR_WIDTH-1:0] Addr_DI;
    logic [1:0]                 RValid_SO;
    logic [63:0]                RdData_DO;

    modport master (
        output Req_SI, WrEn_SI, BEn_SI, WrData_DI, Addr_DI,
        input  Gnt_SO, RValid_SO, RdData_DO
    );

    modport slave (
        input  Req_SI, WrEn_SI, BEn_SI, WrData_DI, Addr_DI,
        output Gnt_SO, RValid_SO, RdData_DO
    );
endinterface
`default_nettype wire

// File: rtl/sram_arb_2p.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : sram_arb_2p                                                    |
// | Brief    : Zero-sweep sequencer and round-robin arbiter for a 64-bit SRAM.|
// | Revision : 1.0                                                            |
// ----------------------------------------------------------------------------
module sram_arb_2p #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_DEPTH = 512,
    parameter int OUT_REGS   = 0,
    parameter int INIT_EN    = 1
) (
    input  wire logic                  Clk_CI,
    input  wire logic                  Rst_RI,
    output logic                       InitDone_SO,
    sram_arb_2p_if.slave               bus,
    output logic                       CSel_SO,
    output logic                       MemWrEn_SO,
    output logic [7:0]                 MemBEn_SO,
    output logic [63:0]                MemWrData_DO,
    output logic [ADDR_WIDTH-1:0]      MemAddr_DO,
    input  wire logic [63:0]           MemRdData_DI
);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int                    c_LAT         = 1 + OUT_REGS;
    localparam logic [ADDR_WIDTH-1:0] c_LAST        = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam state_t                c_RESET_STATE = (INIT_EN != 0) ? S_INIT : S_RUN;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_ptr;
    logic                  r_done;
    logic [1:0]            r_pipe [c_LAT];
    logic [1:0]            w_gnt;
    logic                  w_port;
    logic                  w_xfer;
    logic [1:0]            w_rd_vec;

    assign w_xfer   = |w_gnt;
    assign w_rd_vec = w_gnt & ~bus.WrEn_SI;

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_state <= c_RESET_STATE;
            r_cnt   <= '0;
            r_ptr   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next == S_RUN);
            if (r_state == S_INIT) begin
                r_cnt <= r_cnt + ADDR_WIDTH'(1);
            end
            if (w_xfer) begin
                r_ptr <= ~w_port;
            end
        end
    end

    // One-hot port tag per stage; a zero entry is an empty slot.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            for (int k = 0; k < c_LAT; k++) begin
                r_pipe[k] <= 2'b00;
            end
        end else begin
            r_pipe[0] <= w_rd_vec;
            for (int k = 1; k < c_LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt        = 2'b00;
        w_port       = 1'b0;
        CSel_SO      = 1'b0;
        MemWrEn_SO   = 1'b0;
        MemBEn_SO    = 8'h00;
        MemWrData_DO = 64'h0;
        MemAddr_DO   = '0;
        case (r_state)
            S_INIT: begin
                CSel_SO    = 1'b1;
                MemWrEn_SO = 1'b1;
                MemBEn_SO  = 8'hFF;
                MemAddr_DO = r_cnt;
                if (r_cnt == c_LAST) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                case (bus.Req_SI)
                    2'b01:   w_gnt = 2'b01;
                    2'b10:   w_gnt = 2'b10;
                    2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
                    default: w_gnt = 2'b00;
                endcase
            end
            default: ;
        endcase
        // Reset overrides everything so nothing reaches the macro while held.
        if (Rst_RI) begin
            w_gnt      = 2'b00;
            CSel_SO    = 1'b0;
            MemWrEn_SO = 1'b0;
        end
        w_port = w_gnt[1];
        if (|w_gnt) begin
            CSel_SO      = 1'b1;
            MemWrEn_SO   = bus.WrEn_SI[w_port];
            MemBEn_SO    = bus.BEn_SI[w_port];
            MemWrData_DO = bus.WrData_DI[w_port];
            MemAddr_DO   = bus.Addr_DI[w_port];
        end
    end

    assign bus.Gnt_SO    = w_gnt;
    assign bus.RValid_SO = r_pipe[c_LAT-1];
    assign bus.RdData_DO = MemRdData_DI;
    assign InitDone_SO   = r_done;

endmodule
`default_nettype wire
